// File: rtl/qnt_sched.sv
// qnt_sched: round-robin, block-atomic scheduler that shares one quantizer
// among the Y/Cb/Cr DCT outputs and tags the quantizer results with channel,
// zig-zag index and start/end-of-block markers for the entropy coder.
module qnt_sched #(
  parameter int TAG_DEPTH = 4,
  parameter int NCH       = 3
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [NCH-1:0]           req_valid,
  input  logic [NCH-1:0][31:0]     req_data,
  output logic [NCH-1:0]           req_ready,
  output logic [31:0]              qnt_din,
  output logic                     qnt_din_valid,
  input  logic [7:0]               qnt_dout,
  input  logic                     qnt_dout_valid,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  output logic [1:0]               out_chan,
  output logic [5:0]               out_idx,
  output logic                     out_sob,
  output logic                     out_eob,
  output logic                     busy,
  output logic                     err
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(TAG_DEPTH);

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state;
  logic [1:0]     rr_ptr;
  logic [1:0]     chan;
  logic [5:0]     in_cnt;
  logic [5:0]     out_cnt;

  logic [1:0]     tag_mem [TAG_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  tag_cnt;

  logic           tag_full;
  logic           tag_empty;
  logic           gnt_any;
  logic [1:0]     gnt;
  logic [1:0]     cand;
  logic           push;
  logic           pop;
  logic           accept;

  function automatic logic [1:0] nxt(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign tag_full  = (tag_cnt == FULL_CNT);
  assign tag_empty = (tag_cnt == '0);

  // Round-robin search starting at the channel after the last grant
  always_comb begin
    gnt_any = 1'b0;
    gnt     = '0;
    cand    = rr_ptr;
    for (int unsigned k = 0; k < 3; k++) begin
      cand = nxt(cand);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt     = cand;
      end
    end
  end

  assign push   = (state == IDLE) && gnt_any && !tag_full;
  assign accept = (state == BURST) && req_valid[chan];
  assign pop    = qnt_dout_valid && (out_cnt == 6'd63) && !tag_empty;

  // Ready depends only on state and granted channel, never on valid
  always_comb begin
    req_ready = '0;
    if (state == BURST) req_ready[chan] = 1'b1;
  end

  assign busy = (state == BURST) || !tag_empty;

  // Grant FSM and registered quantizer feed
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= IDLE;
      rr_ptr        <= 2'd2;
      chan          <= '0;
      in_cnt        <= '0;
      qnt_din       <= '0;
      qnt_din_valid <= 1'b0;
    end else begin
      qnt_din_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (push) begin
            chan   <= gnt;
            rr_ptr <= gnt;
            state  <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            qnt_din       <= req_data[chan];
            qnt_din_valid <= 1'b1;
            in_cnt        <= in_cnt + 6'd1;
            if (in_cnt == 6'd63) state <= IDLE;
          end
        end
      endcase
    end
  end

  // Tag storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= gnt;
  end

  // Tag FIFO pointers and occupancy; push+pop together leaves count unchanged
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + CW'(1);
        2'b01:   tag_cnt <= tag_cnt - CW'(1);
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  // Result tagging stage; fields hold when no result arrives
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_idx   <= '0;
      out_sob   <= 1'b0;
      out_eob   <= 1'b0;
      out_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      out_valid <= qnt_dout_valid;
      if (qnt_dout_valid) begin
        out_data <= qnt_dout;
        out_chan <= tag_empty ? 2'd0 : tag_mem[rd_ptr];
        out_idx  <= out_cnt;
        out_sob  <= (out_cnt == 6'd0);
        out_eob  <= (out_cnt == 6'd63);
        out_cnt  <= out_cnt + 6'd1;
        if (tag_empty) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qnt_sched.sv
// Scoreboard bench for qnt_sched: per-channel sources, a stub quantizer that
// can withhold results, and queues of expected quantizer inputs and outputs.
module tb_qnt_sched;

  logic              clk = 1'b0;
  logic              nrst = 1'b1;
  logic [2:0]        req_valid = '0;
  logic [2:0][31:0]  req_data = '0;
  logic [2:0]        req_ready;
  logic [31:0]       qnt_din;
  logic              qnt_din_valid;
  logic [7:0]        qnt_dout = '0;
  logic              qnt_dout_valid = 1'b0;
  logic [7:0]        out_data;
  logic              out_valid;
  logic [1:0]        out_chan;
  logic [5:0]        out_idx;
  logic              out_sob;
  logic              out_eob;
  logic              busy;
  logic              err;

  qnt_sched #(.TAG_DEPTH(4), .NCH(3)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .qnt_din(qnt_din), .qnt_din_valid(qnt_din_valid),
    .qnt_dout(qnt_dout), .qnt_dout_valid(qnt_dout_valid),
    .out_data(out_data), .out_valid(out_valid), .out_chan(out_chan),
    .out_idx(out_idx), .out_sob(out_sob), .out_eob(out_eob),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] chan;
    logic [5:0] idx;
  } item_t;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  bit          en [3];
  bit          tog [3];
  int unsigned quota [3];
  int unsigned sent [3];
  int unsigned exp_seq [3];
  bit          acc [3];
  bit          phase;
  bit          quiet;
  bit          hold;
  int unsigned inject_n;
  int          exp_blk [$];
  int          exp_out [$];
  int unsigned blk_beat;
  logic [31:0] stubq [$];
  item_t       sb [$];
  logic [5:0]  idx_model;
  bit          drove_prev;
  int unsigned cyc, first_v, last_v, nv, viol;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk(input int c, input int unsigned s);
    return (32'(c) << 24) | (s & 32'h0000_ffff);
  endfunction

  function automatic bit all_done();
    bit d = (exp_blk.size() == 0) && (sb.size() == 0) && (stubq.size() == 0)
            && (inject_n == 0) && !drove_prev;
    for (int c = 0; c < 3; c++) if (en[c] && sent[c] < quota[c]) d = 0;
    return d;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 0);
    check({tag, "_din"}, qnt_din, 0);
    check({tag, "_dinv"}, 32'(qnt_din_valid), 0);
    check({tag, "_odata"}, 32'(out_data), 0);
    check({tag, "_ovalid"}, 32'(out_valid), 0);
    check({tag, "_ochan"}, 32'(out_chan), 0);
    check({tag, "_oidx"}, 32'(out_idx), 0);
    check({tag, "_sob"}, 32'(out_sob), 0);
    check({tag, "_eob"}, 32'(out_eob), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_err"}, 32'(err), 0);
  endtask

  // Asserts nrst right now, checks outputs asynchronously, clears bench state
  task automatic hard_reset(input string tag);
    quiet = 1'b1;
    nrst  = 1'b0;
    #1;
    check_reset_outputs(tag);
    repeat (3) @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      en[c] = 0; tog[c] = 0; quota[c] = 0; sent[c] = 0; exp_seq[c] = 0;
    end
    exp_blk.delete(); exp_out.delete(); stubq.delete(); sb.delete();
    blk_beat = 0; idx_model = '0; drove_prev = 0; nv = 0; viol = 0;
    hold = 0; inject_n = 0;
    @(negedge clk);
    nrst  = 1'b1;
    quiet = 1'b0;
  endtask

  task automatic drain(input string tag, input int unsigned budget);
    int unsigned k = 0;
    while (!all_done() && k < budget) begin
      @(posedge clk); #2; k++;
    end
    check({tag, "_drain"}, 32'(all_done()), 1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  function automatic void push_blk(input int c);
    exp_blk.push_back(c);
    exp_out.push_back(c);
  endfunction

  // Cycle engine: requesters, stub quantizer, input/output scoreboards
  initial begin
    item_t it;
    logic [31:0] din;
    logic [7:0]  d;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) acc[c] = req_valid[c] && req_ready[c];
      if (!quiet && tog[1] && sent[1] < quota[1] && (req_ready[0] || req_ready[2])) viol++;
      @(posedge clk);
      #1;
      cyc++;
      if (quiet) begin
        req_valid = '0; qnt_dout_valid = 1'b0; drove_prev = 0;
        continue;
      end
      for (int c = 0; c < 3; c++) if (acc[c]) sent[c]++;
      phase = !phase;
      if (qnt_din_valid) begin
        nv++;
        if (nv == 1) first_v = cyc;
        last_v = cyc;
        stubq.push_back(qnt_din);
        if (exp_blk.size() == 0) check("din_unexpected", 32'(qnt_din_valid), 0);
        else begin
          check("din", qnt_din, mk(exp_blk[0], exp_seq[exp_blk[0]]));
          exp_seq[exp_blk[0]]++;
          blk_beat++;
          if (blk_beat == 64) begin blk_beat = 0; void'(exp_blk.pop_front()); end
        end
      end
      if (drove_prev || out_valid) begin
        check("out_valid", 32'(out_valid), 32'(drove_prev));
        if (out_valid && sb.size() != 0) begin
          it = sb.pop_front();
          check("out_data", 32'(out_data), 32'(it.data));
          check("out_chan", 32'(out_chan), 32'(it.chan));
          check("out_idx", 32'(out_idx), 32'(it.idx));
          check("out_sob", 32'(out_sob), 32'(it.idx == 6'd0));
          check("out_eob", 32'(out_eob), 32'(it.idx == 6'd63));
        end
      end
      drove_prev = 0;
      qnt_dout_valid = 1'b0;
      if (inject_n > 0 || (!hold && stubq.size() != 0)) begin
        if (inject_n > 0) begin
          inject_n--;
          d = 8'hA5 ^ inject_n[7:0];
        end else begin
          din = stubq.pop_front();
          d = din[7:0] + 8'h5A;
        end
        qnt_dout = d;
        qnt_dout_valid = 1'b1;
        drove_prev = 1;
        it.data = d;
        it.chan = (exp_out.size() != 0) ? exp_out[0][1:0] : 2'd0;
        it.idx  = idx_model;
        if (idx_model == 6'd63 && exp_out.size() != 0) void'(exp_out.pop_front());
        idx_model = idx_model + 6'd1;
        sb.push_back(it);
      end
      for (int c = 0; c < 3; c++) begin
        req_valid[c] = en[c] && (sent[c] < quota[c]) && (!tog[c] || phase);
        req_data[c]  = mk(c, sent[c]);
      end
    end
  end

  initial begin
    int unsigned k;
    #2;
    hard_reset("rst0");

    // Single Y block
    en[0] = 1; quota[0] = 64; push_blk(0);
    drain("y1", 400);
    check("y1_beats", nv, 64);
    check("y1_busy_after", 32'(busy), 0);

    // Three channels continuously for six blocks
    hard_reset("rst1");
    for (int r = 0; r < 2; r++) for (int c = 0; c < 3; c++) push_blk(c);
    for (int c = 0; c < 3; c++) begin en[c] = 1; quota[c] = 128; end
    drain("rr", 2000);
    check("rr_beats", nv, 384);
    check("rr_span", last_v - first_v + 1, 6 * 64 + 5);

    // Cb with gaps; Y/Cr raise valid mid-block but must wait
    hard_reset("rst2");
    en[1] = 1; tog[1] = 1; quota[1] = 64; push_blk(1);
    k = 0;
    while (req_ready[1] !== 1'b1 && k < 20) begin @(posedge clk); #2; k++; end
    check("cb_grant", 32'(req_ready), 32'b010);
    en[0] = 1; quota[0] = 64; en[2] = 1; quota[2] = 64;
    push_blk(2); push_blk(0);
    drain("gap", 2000);
    check("gap_foreign_ready", viol, 0);

    // Quantizer withholds results: only TAG_DEPTH blocks may be in flight
    hard_reset("rst3");
    hold = 1; en[0] = 1; quota[0] = 320;
    for (int b = 0; b < 5; b++) push_blk(0);
    repeat (400) @(posedge clk);
    #2;
    check("full_sent", sent[0], 256);
    check("full_ready", 32'(req_ready), 0);
    check("full_busy", 32'(busy), 1);
    check("full_beats", nv, 256);
    hold = 0;
    drain("full", 2000);
    check("full_sent_end", sent[0], 320);
    check("full_busy_end", 32'(busy), 0);

    // Reset in the middle of a Cr block
    hard_reset("rst4");
    en[2] = 1; quota[2] = 64; push_blk(2);
    k = 0;
    while (sent[2] < 30 && k < 200) begin @(posedge clk); #2; k++; end
    check("cr_partial", 32'(sent[2] >= 30), 1);
    #2;
    hard_reset("midrst");
    en[0] = 1; quota[0] = 64; en[2] = 1; quota[2] = 64;
    push_blk(0); push_blk(2);
    drain("post_rst", 1000);

    // Results with no tag outstanding
    inject_n = 64;
    drain("inject", 200);
    check("err_set", 32'(err), 1);
    en[1] = 1; quota[1] = 64; push_blk(1);
    drain("after_err", 400);
    check("err_sticky", 32'(err), 1);
    check("busy_final", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
